// File: rtl/gate_trainer_pkg.sv
// Shared constants for the gate test sequencer: opcodes, vector range and FSM states.
package gate_trainer_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  localparam int unsigned NUM_VECTORS = 28;
  localparam logic [4:0]  LAST_VECTOR = 5'(NUM_VECTORS - 1);
  localparam logic [4:0]  FAIL_NONE   = 5'd31;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t APPLY = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden result for one gate vector.
module gate_ref_model
  import gate_trainer_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] sel,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (sel)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_NOT:  expected = ~a;
      OP_NAND: expected = ~(a & b);
      OP_NOR:  expected = ~(a | b);
      OP_XOR:  expected = a ^ b;
      OP_XNOR: expected = ~(a ^ b);
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks all 28 gate vectors, holds each HOLD_CYCLES clocks and scores the returned result.
module gate_test_sequencer
  import gate_trainer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic [2:0] sel_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [4:0] fail_idx
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [4:0] vec;
  logic [3:0] hold;
  logic       expected;

  gate_ref_model u_ref (
    .a        (vec[1]),
    .b        (vec[0]),
    .sel      (vec[4:2]),
    .expected (expected)
  );

  // vec is only nonzero outside IDLE, so the driven operands read straight from it
  assign {sel_out, a_out, b_out} = vec;

  assign busy = (state == APPLY);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      hold     <= '0;
      err_cnt  <= '0;
      fail_idx <= FAIL_NONE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= APPLY;
            vec      <= '0;
            hold     <= '0;
            err_cnt  <= '0;
            fail_idx <= FAIL_NONE;
          end
        end
        APPLY: begin
          if (hold == HOLD_LAST) begin
            if (y_in != expected) begin
              err_cnt <= err_cnt + 5'd1;
              if (fail_idx == FAIL_NONE) fail_idx <= vec;
            end
            if (vec == LAST_VECTOR) begin
              state <= DONE;
            end else begin
              vec  <= vec + 5'd1;
              hold <= '0;
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
